// File: rtl/cfu_wrr_arbiter.sv
// Weighted round-robin sharing of one CFU-L2 target port among N_INIS initiators.
// An initiator-ID FIFO routes target responses back to their owners in issue order.
module cfu_wrr_arbiter #(
    parameter int N_INIS     = 2,
    parameter int CFU_ID_W   = 1,
    parameter int STATE_ID_W = 1,
    parameter int FUNC_ID_W  = 10,
    parameter int DATA_W     = 32,
    parameter int STATUS_W   = 3,
    parameter int WEIGHT     = 4,
    parameter int N_REQS     = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clk_en,
    input  logic [N_INIS-1:0]                i_req_valids,
    output logic [N_INIS-1:0]                i_req_readys,
    input  logic [N_INIS*CFU_ID_W-1:0]       i_req_cfus,
    input  logic [N_INIS*STATE_ID_W-1:0]     i_req_states,
    input  logic [N_INIS*FUNC_ID_W-1:0]      i_req_funcs,
    input  logic [N_INIS*DATA_W-1:0]         i_req_data0s,
    input  logic [N_INIS*DATA_W-1:0]         i_req_data1s,
    output logic [N_INIS-1:0]                i_resp_valids,
    input  logic [N_INIS-1:0]                i_resp_readys,
    output logic [N_INIS*STATUS_W-1:0]       i_resp_statuss,
    output logic [N_INIS*DATA_W-1:0]         i_resp_datas,
    output logic                             t_req_valid,
    input  logic                             t_req_ready,
    output logic [CFU_ID_W-1:0]              t_req_cfu,
    output logic [STATE_ID_W-1:0]            t_req_state,
    output logic [FUNC_ID_W-1:0]             t_req_func,
    output logic [DATA_W-1:0]                t_req_data0,
    output logic [DATA_W-1:0]                t_req_data1,
    input  logic                             t_resp_valid,
    output logic                             t_resp_ready,
    input  logic [STATUS_W-1:0]              t_resp_status,
    input  logic [DATA_W-1:0]                t_resp_data,
    output logic [$clog2(N_REQS):0]          n_inflight,
    output logic                             err_orphan
);

    localparam int IDX_W   = (N_INIS > 1) ? $clog2(N_INIS) : 1;
    localparam int PTR_W   = (N_REQS > 1) ? $clog2(N_REQS) : 1;
    localparam int CNT_W   = $clog2(N_REQS) + 1;
    localparam int BURST_W = $clog2(WEIGHT + 1);

    logic [IDX_W-1:0]           owner_q, owner_d;
    logic [BURST_W-1:0]         burst_q, burst_d;
    logic [IDX_W-1:0]           fifo_q [N_REQS];
    logic [IDX_W-1:0]           fifo_d [N_REQS];
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       t_req_valid_q, t_req_valid_d;
    logic [CFU_ID_W-1:0]        t_req_cfu_q, t_req_cfu_d;
    logic [STATE_ID_W-1:0]      t_req_state_q, t_req_state_d;
    logic [FUNC_ID_W-1:0]       t_req_func_q, t_req_func_d;
    logic [DATA_W-1:0]          t_req_data0_q, t_req_data0_d;
    logic [DATA_W-1:0]          t_req_data1_q, t_req_data1_d;
    logic [N_INIS-1:0]          resp_valid_q, resp_valid_d;
    logic [N_INIS*STATUS_W-1:0] resp_status_q, resp_status_d;
    logic [N_INIS*DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                       err_orphan_q, err_orphan_d;

    logic                       others_req;
    logic                       grant;
    logic                       found;
    logic [IDX_W-1:0]           grant_idx;
    logic [IDX_W-1:0]           cand;
    logic                       fifo_empty;
    logic [IDX_W-1:0]           head;
    logic                       resp_pop;

    // Arbitration: owner keeps the port until its burst is spent and someone else waits.
    always_comb begin
        others_req = 1'b0;
        for (int i = 0; i < N_INIS; i++) begin
            if (IDX_W'(i) != owner_q) others_req = others_req | i_req_valids[i];
        end
        found     = 1'b0;
        grant_idx = owner_q;
        cand      = owner_q;
        if (i_req_valids[owner_q] && ((burst_q < BURST_W'(WEIGHT)) || !others_req)) begin
            found = 1'b1;
        end else begin
            for (int k = 1; k <= N_INIS; k++) begin
                cand = IDX_W'((int'(owner_q) + k) % N_INIS);
                if (!found && i_req_valids[cand]) begin
                    found     = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        grant = (!t_req_valid_q || t_req_ready) && (count_q != CNT_W'(N_REQS)) &&
                (|i_req_valids) && found;
        i_req_readys = grant ? (N_INIS'(1) << grant_idx) : '0;
    end

    always_comb begin
        fifo_empty   = (count_q == '0);
        head         = fifo_q[rd_ptr_q];
        t_resp_ready = !fifo_empty && (!resp_valid_q[head] || i_resp_readys[head]);
        resp_pop     = t_resp_valid && t_resp_ready;
    end

    always_comb begin
        owner_d       = owner_q;
        burst_d       = burst_q;
        fifo_d        = fifo_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        t_req_valid_d = t_req_valid_q;
        t_req_cfu_d   = t_req_cfu_q;
        t_req_state_d = t_req_state_q;
        t_req_func_d  = t_req_func_q;
        t_req_data0_d = t_req_data0_q;
        t_req_data1_d = t_req_data1_q;
        resp_valid_d  = resp_valid_q;
        resp_status_d = resp_status_q;
        resp_data_d   = resp_data_q;
        err_orphan_d  = err_orphan_q | (t_resp_valid && fifo_empty);
        count_d       = count_q + CNT_W'(grant) - CNT_W'(resp_pop);

        if (grant) begin
            fifo_d[wr_ptr_q] = grant_idx;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            t_req_valid_d    = 1'b1;
            t_req_cfu_d      = i_req_cfus[grant_idx*CFU_ID_W +: CFU_ID_W];
            t_req_state_d    = i_req_states[grant_idx*STATE_ID_W +: STATE_ID_W];
            t_req_func_d     = i_req_funcs[grant_idx*FUNC_ID_W +: FUNC_ID_W];
            t_req_data0_d    = i_req_data0s[grant_idx*DATA_W +: DATA_W];
            t_req_data1_d    = i_req_data1s[grant_idx*DATA_W +: DATA_W];
            owner_d          = grant_idx;
            if (grant_idx == owner_q) begin
                burst_d = (burst_q >= BURST_W'(WEIGHT)) ? BURST_W'(WEIGHT) : burst_q + BURST_W'(1);
            end else begin
                burst_d = BURST_W'(1);
            end
        end else if (t_req_ready) begin
            t_req_valid_d = 1'b0;
        end

        if (resp_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        for (int i = 0; i < N_INIS; i++) begin
            if (resp_pop && (head == IDX_W'(i))) begin
                resp_valid_d[i]                         = 1'b1;
                resp_status_d[i*STATUS_W +: STATUS_W]   = t_resp_status;
                resp_data_d[i*DATA_W +: DATA_W]         = t_resp_data;
            end else if (i_resp_readys[i]) begin
                resp_valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q       <= '0;
            burst_q       <= '0;
            for (int i = 0; i < N_REQS; i++) fifo_q[i] <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            t_req_valid_q <= 1'b0;
            t_req_cfu_q   <= '0;
            t_req_state_q <= '0;
            t_req_func_q  <= '0;
            t_req_data0_q <= '0;
            t_req_data1_q <= '0;
            resp_valid_q  <= '0;
            resp_status_q <= '0;
            resp_data_q   <= '0;
            err_orphan_q  <= 1'b0;
        end else if (clk_en) begin
            owner_q       <= owner_d;
            burst_q       <= burst_d;
            fifo_q        <= fifo_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            t_req_valid_q <= t_req_valid_d;
            t_req_cfu_q   <= t_req_cfu_d;
            t_req_state_q <= t_req_state_d;
            t_req_func_q  <= t_req_func_d;
            t_req_data0_q <= t_req_data0_d;
            t_req_data1_q <= t_req_data1_d;
            resp_valid_q  <= resp_valid_d;
            resp_status_q <= resp_status_d;
            resp_data_q   <= resp_data_d;
            err_orphan_q  <= err_orphan_d;
        end
    end

    assign t_req_valid    = t_req_valid_q;
    assign t_req_cfu      = t_req_cfu_q;
    assign t_req_state    = t_req_state_q;
    assign t_req_func     = t_req_func_q;
    assign t_req_data0    = t_req_data0_q;
    assign t_req_data1    = t_req_data1_q;
    assign i_resp_valids  = resp_valid_q;
    assign i_resp_statuss = resp_status_q;
    assign i_resp_datas   = resp_data_q;
    assign n_inflight     = count_q;
    assign err_orphan     = err_orphan_q;

endmodule

// File: tb/tb_cfu_wrr_arbiter.sv
// Randomized scoreboard bench for cfu_wrr_arbiter: a reference model predicts grants,
// target requests and per-initiator responses; a monitor checks them as they appear.
module tb_cfu_wrr_arbiter;

    localparam int N   = 2;
    localparam int CW  = 1;
    localparam int SW  = 1;
    localparam int FW  = 10;
    localparam int DW  = 32;
    localparam int STW = 3;
    localparam int WT  = 4;
    localparam int NR  = 8;

    logic                clk;
    logic                rst;
    logic                clk_en;
    logic [N-1:0]        i_req_valids;
    logic [N-1:0]        i_req_readys;
    logic [N*CW-1:0]     i_req_cfus;
    logic [N*SW-1:0]     i_req_states;
    logic [N*FW-1:0]     i_req_funcs;
    logic [N*DW-1:0]     i_req_data0s;
    logic [N*DW-1:0]     i_req_data1s;
    logic [N-1:0]        i_resp_valids;
    logic [N-1:0]        i_resp_readys;
    logic [N*STW-1:0]    i_resp_statuss;
    logic [N*DW-1:0]     i_resp_datas;
    logic                t_req_valid;
    logic                t_req_ready;
    logic [CW-1:0]       t_req_cfu;
    logic [SW-1:0]       t_req_state;
    logic [FW-1:0]       t_req_func;
    logic [DW-1:0]       t_req_data0;
    logic [DW-1:0]       t_req_data1;
    logic                t_resp_valid;
    logic                t_resp_ready;
    logic [STW-1:0]      t_resp_status;
    logic [DW-1:0]       t_resp_data;
    logic [$clog2(NR):0] n_inflight;
    logic                err_orphan;

    cfu_wrr_arbiter #(
        .N_INIS(N), .CFU_ID_W(CW), .STATE_ID_W(SW), .FUNC_ID_W(FW),
        .DATA_W(DW), .STATUS_W(STW), .WEIGHT(WT), .N_REQS(NR)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .i_req_valids(i_req_valids), .i_req_readys(i_req_readys),
        .i_req_cfus(i_req_cfus), .i_req_states(i_req_states), .i_req_funcs(i_req_funcs),
        .i_req_data0s(i_req_data0s), .i_req_data1s(i_req_data1s),
        .i_resp_valids(i_resp_valids), .i_resp_readys(i_resp_readys),
        .i_resp_statuss(i_resp_statuss), .i_resp_datas(i_resp_datas),
        .t_req_valid(t_req_valid), .t_req_ready(t_req_ready),
        .t_req_cfu(t_req_cfu), .t_req_state(t_req_state), .t_req_func(t_req_func),
        .t_req_data0(t_req_data0), .t_req_data1(t_req_data1),
        .t_resp_valid(t_resp_valid), .t_resp_ready(t_resp_ready),
        .t_resp_status(t_resp_status), .t_resp_data(t_resp_data),
        .n_inflight(n_inflight), .err_orphan(err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] cfu;
        logic [SW-1:0] st;
        logic [FW-1:0] fn;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } treq_t;

    treq_t              exp_treq [$];
    logic [STW+DW-1:0]  exp_resp [N][$];
    int                 errors = 0;
    int                 checks = 0;
    int                 tgt_pending = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    // Reference model: evaluated mid-cycle, predicts the coming clock edge.
    initial begin
        int    m_ids [$];
        int    m_owner;
        int    m_burst;
        bit    m_tv;
        bit    m_err;
        bit    m_rv [N];
        bit    armed;
        bit    just_reset;
        bit    any;
        bit    others;
        bit    can;
        bit    ne;
        bit    exp_trr;
        bit    rhs;
        int    g;
        int    c;
        int    h;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] rvp;
        treq_t t;
        armed = 0;
        just_reset = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_ids.delete();
                m_owner = 0; m_burst = 0; m_tv = 0; m_err = 0;
                for (int i = 0; i < N; i++) m_rv[i] = 0;
                tgt_pending = 0;
                armed = 1;
                just_reset = 1;
                continue;
            end
            if (!armed) continue;

            any = |i_req_valids;
            others = 0;
            for (int i = 0; i < N; i++) if (i != m_owner && i_req_valids[i]) others = 1;
            can = (!m_tv || t_req_ready) && (m_ids.size() < NR) && any;
            g = -1;
            if (i_req_valids[m_owner] && (m_burst < WT || !others)) g = m_owner;
            else for (int k = 1; k <= N; k++) begin
                c = (m_owner + k) % N;
                if (g < 0 && i_req_valids[c]) g = c;
            end
            exp_rdy = can ? (N'(1) << g) : '0;
            ne = m_ids.size() > 0;
            h = ne ? m_ids[0] : 0;
            exp_trr = ne && (!m_rv[h] || i_resp_readys[h]);
            for (int i = 0; i < N; i++) rvp[i] = m_rv[i];

            chk("i_req_readys", 128'(i_req_readys), 128'(exp_rdy));
            chk("t_resp_ready", 128'(t_resp_ready), 128'(exp_trr));
            chk("t_req_valid", 128'(t_req_valid), 128'(m_tv));
            chk("i_resp_valids", 128'(i_resp_valids), 128'(rvp));
            chk("n_inflight", 128'(n_inflight), 128'(m_ids.size()));
            chk("err_orphan", 128'(err_orphan), 128'(m_err));
            if (just_reset) begin
                chk("reset_t_req_fields", 128'({t_req_cfu, t_req_state, t_req_func, t_req_data0, t_req_data1}), 128'(0));
                chk("reset_i_resp_fields", 128'({i_resp_statuss, i_resp_datas}), 128'(0));
                just_reset = 0;
            end

            if (clk_en) begin
                rhs = t_resp_valid && exp_trr;
                if (m_tv && t_req_ready) tgt_pending++;
                if (rhs) tgt_pending--;
                if (t_resp_valid && !ne) m_err = 1;
                for (int i = 0; i < N; i++) begin
                    if (rhs && h == i) begin
                        m_rv[i] = 1;
                        exp_resp[i].push_back({t_resp_status, t_resp_data});
                    end else if (i_resp_readys[i]) begin
                        m_rv[i] = 0;
                    end
                end
                if (rhs) void'(m_ids.pop_front());
                if (can) begin
                    m_ids.push_back(g);
                    t.cfu = i_req_cfus[g*CW +: CW];
                    t.st  = i_req_states[g*SW +: SW];
                    t.fn  = i_req_funcs[g*FW +: FW];
                    t.d0  = i_req_data0s[g*DW +: DW];
                    t.d1  = i_req_data1s[g*DW +: DW];
                    exp_treq.push_back(t);
                    m_burst = (g == m_owner) ? ((m_burst + 1 > WT) ? WT : m_burst + 1) : 1;
                    m_owner = g;
                    m_tv = 1;
                end else if (t_req_ready) begin
                    m_tv = 0;
                end
            end
        end
    end

    // Monitor: compares every accepted target request and delivered initiator response.
    initial begin
        treq_t got;
        treq_t want;
        logic [STW+DW-1:0] rexp;
        forever begin
            @(negedge clk);
            if (clk_en) begin
                if (t_req_valid === 1'b1 && t_req_ready) begin
                    got = {t_req_cfu, t_req_state, t_req_func, t_req_data0, t_req_data1};
                    if (exp_treq.size() == 0) chk("t_req_unexpected", 128'(got), 128'(0) - 1);
                    else begin
                        want = exp_treq.pop_front();
                        chk("t_req_fields", 128'(got), 128'(want));
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (i_resp_valids[i] === 1'b1 && i_resp_readys[i]) begin
                        if (exp_resp[i].size() == 0) chk("i_resp_unexpected", 128'(i), 128'(N));
                        else begin
                            rexp = exp_resp[i].pop_front();
                            chk($sformatf("i_resp%0d", i),
                                128'({i_resp_statuss[i*STW +: STW], i_resp_datas[i*DW +: DW]}), 128'(rexp));
                        end
                    end
                end
            end
            if (rst) begin
                exp_treq.delete();
                for (int i = 0; i < N; i++) exp_resp[i].delete();
            end
        end
    end

    task automatic drive(input logic [N-1:0] vmask, input int pv, input int ptr,
                         input int prsp, input int prr, input int pce);
        for (int i = 0; i < N; i++) begin
            i_req_valids[i]            = vmask[i] && roll(pv);
            i_req_cfus[i*CW +: CW]     = CW'($urandom);
            i_req_states[i*SW +: SW]   = SW'($urandom);
            i_req_funcs[i*FW +: FW]    = FW'($urandom);
            i_req_data0s[i*DW +: DW]   = $urandom;
            i_req_data1s[i*DW +: DW]   = $urandom;
            i_resp_readys[i]           = roll(prr);
        end
        t_req_ready   = roll(ptr);
        clk_en        = roll(pce);
        t_resp_valid  = (tgt_pending > 0) && roll(prsp);
        t_resp_status = STW'($urandom);
        t_resp_data   = $urandom;
    endtask

    task automatic run(input int n, input logic [N-1:0] vmask, input int pv, input int ptr,
                       input int prsp, input int prr, input int pce);
        repeat (n) begin
            @(posedge clk); #1;
            drive(vmask, pv, ptr, prsp, prr, pce);
        end
    endtask

    task automatic quiet();
        i_req_valids  = '0;
        i_resp_readys = '0;
        t_req_ready   = 1'b0;
        t_resp_valid  = 1'b0;
        clk_en        = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        quiet();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic orphan_pulse();
        @(posedge clk); #1;
        quiet();
        i_resp_readys = '1;
        t_resp_valid  = 1'b1;
        t_resp_status = 3'd5;
        t_resp_data   = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        t_resp_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        i_req_cfus = '0; i_req_states = '0; i_req_funcs = '0;
        i_req_data0s = '0; i_req_data1s = '0;
        t_resp_status = '0; t_resp_data = '0;
        do_reset();
        orphan_pulse();
        run(4, 2'b00, 0, 100, 0, 100, 100);
        do_reset();
        run(20, 2'b01, 100, 100, 100, 100, 100);
        run(60, 2'b11, 100, 100, 100, 100, 100);
        run(15, 2'b10, 100, 100, 100, 100, 100);
        run(20, 2'b11, 100, 100, 0, 100, 100);
        run(10, 2'b11, 100, 100, 30, 100, 100);
        run(300, 2'b11, 70, 60, 60, 50, 100);
        run(2000, 2'b11, 50, 70, 70, 60, 85);
        run(6, 2'b11, 100, 100, 0, 100, 100);
        do_reset();
        orphan_pulse();
        run(4, 2'b00, 0, 100, 0, 100, 100);
        do_reset();
        run(1500, 2'b11, 60, 50, 50, 40, 90);
        run(60, 2'b00, 0, 100, 100, 100, 100);
        @(negedge clk);
        chk("drain_t_req_queue", 128'(exp_treq.size()), 128'(0));
        for (int i = 0; i < N; i++) chk("drain_i_resp_queue", 128'(exp_resp[i].size()), 128'(0));
        chk("drain_n_inflight", 128'(n_inflight), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cfu_wrr_arbiter.md
Name: cfu_wrr_arbiter

Overview:
- Shares one CFU-L2 target port among N_INIS CFU-L2 initiators using weighted round-robin arbitration.
- Tracks in-flight request ownership in an initiator-ID FIFO and returns target responses to their owners in issue order.
- Used in front of a single expensive CFU, such as a shared multiplier or crypto unit, where a full switch is unnecessary.
- Request and response paths are each registered: one cycle of latency per direction.

Parameters:
- N_INIS, 2, number of initiators (>=2).
- CFU_ID_W, 1, CFU ID width.
- STATE_ID_W, 1, state ID width.
- FUNC_ID_W, 10, function ID width.
- DATA_W, 32, data width.
- STATUS_W, 3, response status width.
- WEIGHT, 4, max consecutive grants to one initiator while another initiator is waiting (>=1).
- N_REQS, 8, max in-flight requests (ID FIFO depth, power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- clk_en  in  1  clock enable; no state changes when low.
- i_req_valids  in  N_INIS  initiator request valids.
- i_req_readys  out  N_INIS  initiator request readys (combinational).
- i_req_cfus  in  N_INIS*CFU_ID_W  initiator CFU IDs.
- i_req_states  in  N_INIS*STATE_ID_W  initiator state IDs.
- i_req_funcs  in  N_INIS*FUNC_ID_W  initiator function IDs.
- i_req_data0s  in  N_INIS*DATA_W  initiator operand 0.
- i_req_data1s  in  N_INIS*DATA_W  initiator operand 1.
- i_resp_valids  out  N_INIS  initiator response valids (registered).
- i_resp_readys  in  N_INIS  initiator response readys.
- i_resp_statuss  out  N_INIS*STATUS_W  initiator response status.
- i_resp_datas  out  N_INIS*DATA_W  initiator response data.
- t_req_valid  out  1  target request valid (registered).
- t_req_ready  in  1  target request ready.
- t_req_cfu, t_req_state, t_req_func, t_req_data0, t_req_data1  out  CFU_ID_W/STATE_ID_W/FUNC_ID_W/DATA_W/DATA_W  target request fields.
- t_resp_valid  in  1  target response valid.
- t_resp_ready  out  1  target response ready (combinational).
- t_resp_status  in  STATUS_W  target response status.
- t_resp_data  in  DATA_W  target response data.
- n_inflight  out  $clog2(N_REQS)+1  current ID FIFO occupancy.
- err_orphan  out  1  sticky: a target response arrived with no request outstanding.

Behaviour:
- Reset values: all valids 0, all data/field outputs 0, owner=0, burst count=0, FIFO empty, n_inflight=0, err_orphan=0.
- Handshake on a port occurs when valid & ready.
- Grant is possible when t_req_valid==0 or t_req_ready==1, FIFO not full, and at least one i_req_valid is set.
- Grant selection:
  - If the owner is requesting and (burst<WEIGHT or no other initiator is requesting), the owner is granted again.
  - Otherwise the first requesting initiator in round-robin order starting at owner+1 (mod N_INIS) is granted.
- On grant g:
  - i_req_readys[g]=1; all other readys 0.
  - Next cycle: t_req_valid=1 and request fields = initiator g's fields, with CFU ID passed through unmodified.
  - g is pushed into the FIFO.
  - owner<=g; burst<=burst+1 (saturating at WEIGHT) if g==owner, else burst<=1.
- Without a grant: t_req_valid clears when t_req_ready=1; otherwise t_req_valid and all request fields hold stable.
- Response path:
  - h = FIFO head.
  - t_resp_ready=1 iff FIFO non-empty and (i_resp_valids[h]==0 or i_resp_readys[h]==1).
  - On a target response handshake: next cycle i_resp_valids[h]=1 with the target's status and data; FIFO pops.
  - An initiator response slot not being loaded clears its valid when i_resp_readys=1.
  - Responses reach each initiator in that initiator's issue order.
- FIFO occupancy:
  - Grant and pop in the same cycle leave occupancy unchanged.
  - Grants stall at occupancy N_REQS, even if a pop occurs that cycle.
  - n_inflight reflects the registered occupancy.
- Orphan response: t_resp_valid with an empty FIFO → t_resp_ready=0, err_orphan<=1 (sticky until rst), no initiator response produced.
- clk_en=0 freezes all registers; combinational readys still evaluate but must be ignored by callers.
- Reset mid-operation discards all in-flight ownership; any later target responses count as orphans.

Test Plan:
- Single initiator 0 with func=5, data0=3, data1=4: t_req_valid one cycle after the handshake with matching fields; t_resp data=7 → i_resp_valids=01 with data 7 one cycle later; n_inflight 1→0.
- Both initiators continuously valid, WEIGHT=4, target always ready: grant sequence 0,0,0,0,1,1,1,1,0…; each grant run is at most 4 long.
- Only initiator 1 valid for 10 cycles: it is granted in all 10 cycles despite WEIGHT=4.
- Target never responds, N_REQS=8: exactly 8 grants, then all i_req_readys=0 and n_inflight=8; one response frees exactly one further grant.
- Interleaved grants 0,1,0 with target responses 0xA,0xB,0xC: initiator 0 receives A then C, initiator 1 receives B. Holding i_resp_readys[0]=0 blocks t_resp_ready while the head is initiator 0.
- t_resp_valid asserted after reset with no requests: t_resp_ready=0 and err_orphan=1 next cycle, staying 1 until rst.
